// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: consumer-side read controller for a synchronous FIFO with registered data_out.
// Latency: 2 clk from rd_en to m_valid; full throughput of 1 word/clk while m_ready is held high.
// Backpressure: credit-gated reads with a 2-entry buffer; m_data holds while m_valid && !m_ready.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   fifo_data_out/empty/underflow  FIFO read-side interface (data valid the cycle after a read)
//   rd_en                          FIFO read enable (combinational; depends on m_ready)
//   m_valid/m_ready/m_data         downstream valid/ready stream
//   err_underflow                  sticky FIFO underflow flag, cleared only by reset
//   rd_word_cnt, uf_cnt            saturating statistics, present only with FIFO_RD_STATS_EN
//
// Optional feature macro: FIFO_RD_STATS_EN (adds rd_word_cnt and uf_cnt).
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  err_underflow
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_word_cnt,
  output logic [CNT_WIDTH-1:0]  uf_cnt
`endif
);

  logic [1:0]            occ;       // words held in the output buffer (0..2)
  logic                  inflight;  // a read was accepted last cycle; its word arrives now
  logic                  head;      // index of the oldest buffered word
  logic [FIFO_WIDTH-1:0] mem [2];

  logic pop;
  logic tail;

  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[head];
  assign pop     = m_valid && m_ready;

  // With occ <= 2 and head being 1 bit, head + occ mod 2 reduces to an XOR with occ[0].
  assign tail = head ^ occ[0];

  // Credit rule: buffered + in-flight words must stay within the 2 slots, counting the
  // slot freed by a pop this cycle. Gated by rst_n so no read is issued during reset.
  assign rd_en = rst_n && !fifo_empty &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ           <= 2'd0;
      inflight      <= 1'b0;
      head          <= 1'b0;
      mem[0]        <= '0;
      mem[1]        <= '0;
      err_underflow <= 1'b0;
    end else begin
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      inflight <= rd_en;
      head     <= head ^ pop;
      // Returned word goes to the tail slot; no bypass to m_data even when occ == 0.
      if (inflight) begin
        mem[tail] <= fifo_data_out;
      end
      if (fifo_underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_word_cnt <= '0;
      uf_cnt      <= '0;
    end else begin
      if (pop && (rd_word_cnt != {CNT_WIDTH{1'b1}})) begin
        rd_word_cnt <= rd_word_cnt + 1'b1;
      end
      if (fifo_underflow && (uf_cnt != {CNT_WIDTH{1'b1}})) begin
        uf_cnt <= uf_cnt + 1'b1;
      end
    end
  end
`else
  // Keeps CNT_WIDTH referenced when statistics are compiled out.
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule
